// File: rtl/ysyx_mem_arb.sv
// Two-requester memory arbiter: LSU has priority, and a starvation counter makes sure fetch still makes progress.
// Latency is 1 grant cycle plus 1 address cycle plus the slave's latency. Requests wait while busy, with one transaction in flight at a time.
module ysyx_mem_arb #(
    parameter int BIT_W      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ifu_avalid,
    input  logic [BIT_W-1:0]   ifu_addr,
    output logic [BIT_W-1:0]   ifu_rdata,
    output logic               ifu_rvalid,
    output logic               ifu_err,
    input  logic               lsu_avalid,
    input  logic               lsu_ren,
    input  logic               lsu_wen,
    input  logic [BIT_W-1:0]   lsu_addr,
    input  logic [BIT_W-1:0]   lsu_wdata,
    input  logic [BIT_W/8-1:0] lsu_wstrb,
    output logic [BIT_W-1:0]   lsu_rdata,
    output logic               lsu_rvalid,
    output logic               lsu_wready,
    output logic               lsu_err,
    output logic               bus_arvalid,
    output logic [BIT_W-1:0]   bus_araddr,
    input  logic               bus_arready,
    input  logic               bus_rvalid,
    input  logic [BIT_W-1:0]   bus_rdata,
    input  logic [1:0]         bus_rresp,
    output logic               bus_awvalid,
    output logic [BIT_W-1:0]   bus_awaddr,
    output logic [BIT_W-1:0]   bus_wdata,
    output logic [BIT_W/8-1:0] bus_wstrb,
    input  logic               bus_awready,
    input  logic               bus_bvalid,
    input  logic [1:0]         bus_bresp
);
    typedef enum logic [2:0] {
        IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t             state, state_nxt;
    logic [3:0]         starve_cnt, starve_cnt_nxt;
    logic [BIT_W-1:0]   addr_q, addr_nxt;
    logic [BIT_W-1:0]   wdata_q, wdata_nxt;
    logic [BIT_W/8-1:0] wstrb_q, wstrb_nxt;
    logic               lsu_req, lsu_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            wstrb_q    <= wstrb_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        addr_nxt       = addr_q;
        wdata_nxt      = wdata_q;
        wstrb_nxt      = wstrb_q;
        lsu_req        = lsu_avalid & (lsu_ren | lsu_wen);
        lsu_win        = lsu_req & (~ifu_avalid | (starve_cnt < STARVE_LIM));
        case (state)
            IDLE: begin
                if (lsu_win) begin
                    state_nxt = lsu_wen ? LSU_W : LSU_AR;
                    addr_nxt  = lsu_addr;
                    wdata_nxt = lsu_wdata;
                    wstrb_nxt = lsu_wstrb;
                    // Only LSU wins taken over a waiting fetch count toward starvation.
                    if (!ifu_avalid)
                        starve_cnt_nxt = '0;
                    else if (starve_cnt != STARVE_LIM)
                        starve_cnt_nxt = starve_cnt + 4'd1;
                end else if (ifu_avalid) begin
                    state_nxt      = IFU_AR;
                    addr_nxt       = ifu_addr;
                    wdata_nxt      = '0;
                    wstrb_nxt      = '0;
                    starve_cnt_nxt = '0;
                end
            end
            IFU_AR: if (bus_arready) state_nxt = IFU_R;
            IFU_R:  if (bus_rvalid)  state_nxt = IDLE;
            LSU_AR: if (bus_arready) state_nxt = LSU_R;
            LSU_R:  if (bus_rvalid)  state_nxt = IDLE;
            LSU_W:  if (bus_awready) state_nxt = LSU_B;
            LSU_B:  if (bus_bvalid)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gating with rst means a reset mid-transaction never leaks a response pulse.
    assign bus_arvalid = ~rst & ((state == IFU_AR) | (state == LSU_AR));
    assign bus_awvalid = ~rst & (state == LSU_W);
    assign bus_araddr  = addr_q;
    assign bus_awaddr  = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_wstrb   = wstrb_q;

    assign ifu_rvalid  = ~rst & (state == IFU_R) & bus_rvalid;
    assign lsu_rvalid  = ~rst & (state == LSU_R) & bus_rvalid;
    assign lsu_wready  = ~rst & (state == LSU_B) & bus_bvalid;
    assign ifu_rdata   = ifu_rvalid ? bus_rdata : '0;
    assign lsu_rdata   = lsu_rvalid ? bus_rdata : '0;
    assign ifu_err     = ifu_rvalid & (|bus_rresp);
    assign lsu_err     = (lsu_rvalid & (|bus_rresp)) | (lsu_wready & (|bus_bresp));
endmodule

// File: tb/tb_ysyx_mem_arb.sv
// Bench for ysyx_mem_arb: a delay-configurable slave, table-driven single transactions,
// per-requester response scoreboards, a reset-abort sequence and a starvation sequence.
module tb_ysyx_mem_arb;
    logic        clk, rst;
    logic        ifu_avalid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        ifu_rvalid, ifu_err;
    logic        lsu_avalid, lsu_ren, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_rvalid, lsu_wready, lsu_err;
    logic        bus_arvalid, bus_arready, bus_rvalid;
    logic [31:0] bus_araddr, bus_rdata;
    logic [1:0]  bus_rresp, bus_bresp;
    logic        bus_awvalid, bus_awready, bus_bvalid;
    logic [31:0] bus_awaddr, bus_wdata;
    logic [3:0]  bus_wstrb;

    ysyx_mem_arb #(.BIT_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_avalid(ifu_avalid), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata),
        .ifu_rvalid(ifu_rvalid), .ifu_err(ifu_err),
        .lsu_avalid(lsu_avalid), .lsu_ren(lsu_ren), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_wready(lsu_wready), .lsu_err(lsu_err),
        .bus_arvalid(bus_arvalid), .bus_araddr(bus_araddr), .bus_arready(bus_arready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rresp(bus_rresp),
        .bus_awvalid(bus_awvalid), .bus_awaddr(bus_awaddr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_awready(bus_awready), .bus_bvalid(bus_bvalid),
        .bus_bresp(bus_bresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave: arready/awready after cfg_a wait cycles, rvalid/bvalid cfg_d cycles later.
    int          cfg_a = 0, cfg_d = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_resp = '0;
    int          s_ar_cnt, s_r_cnt, s_aw_cnt, s_b_cnt;
    logic        s_r_pend, s_b_pend;
    logic [31:0] s_ar_addr;

    assign bus_arready = bus_arvalid && (s_ar_cnt == cfg_a);
    assign bus_rvalid  = s_r_pend && (s_r_cnt == cfg_d);
    assign bus_rdata   = cfg_rdata ^ (s_ar_addr << 16);
    assign bus_rresp   = cfg_resp;
    assign bus_awready = bus_awvalid && (s_aw_cnt == cfg_a);
    assign bus_bvalid  = s_b_pend && (s_b_cnt == cfg_d);
    assign bus_bresp   = cfg_resp;

    always @(posedge clk) begin
        if (rst) begin
            s_ar_cnt <= 0; s_r_cnt <= 0; s_aw_cnt <= 0; s_b_cnt <= 0;
            s_r_pend <= 1'b0; s_b_pend <= 1'b0; s_ar_addr <= '0;
        end else begin
            if (bus_arvalid) begin
                if (bus_arready) begin
                    s_ar_cnt <= 0; s_r_pend <= 1'b1; s_r_cnt <= 0; s_ar_addr <= bus_araddr;
                end else s_ar_cnt <= s_ar_cnt + 1;
            end
            if (s_r_pend) begin
                if (bus_rvalid) s_r_pend <= 1'b0;
                else s_r_cnt <= s_r_cnt + 1;
            end
            if (bus_awvalid) begin
                if (bus_awready) begin
                    s_aw_cnt <= 0; s_b_pend <= 1'b1; s_b_cnt <= 0;
                end else s_aw_cnt <= s_aw_cnt + 1;
            end
            if (s_b_pend) begin
                if (bus_bvalid) s_b_pend <= 1'b0;
                else s_b_cnt <= s_b_cnt + 1;
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        bit          err;
        bit          wr;
    } rsp_t;

    rsp_t        ifu_sb[$];
    rsp_t        lsu_sb[$];
    logic [31:0] grant_log[$];
    bit          chk_on = 0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    int          m_ar_cyc, m_aw_cyc;

    initial begin : monitor
        bit   prev_v;
        rsp_t e;
        prev_v = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifu_rvalid) begin
                    if (ifu_sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL ifu_unexpected_rsp: got rvalid=1 required no response");
                    end else begin
                        e = ifu_sb.pop_front();
                        chk("ifu_rdata", ifu_rdata, e.data);
                        chk("ifu_err", 32'(ifu_err), 32'(e.err));
                    end
                end
                if (lsu_rvalid || lsu_wready) begin
                    if (lsu_sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL lsu_unexpected_rsp: got rvalid=%0d wready=%0d required no response",
                                 lsu_rvalid, lsu_wready);
                    end else begin
                        e = lsu_sb.pop_front();
                        chk("lsu_rsp_is_write", 32'(lsu_wready), 32'(e.wr));
                        if (!e.wr) chk("lsu_rdata", lsu_rdata, e.data);
                        chk("lsu_err", 32'(lsu_err), 32'(e.err));
                    end
                end
                chk("err_outside_rsp", 32'((ifu_err & ~ifu_rvalid) | (lsu_err & ~(lsu_rvalid | lsu_wready))), 32'd0);
                if (bus_arvalid) m_ar_cyc++;
                if (bus_awvalid) m_aw_cyc++;
                if ((bus_arvalid || bus_awvalid) && !prev_v)
                    grant_log.push_back(bus_arvalid ? bus_araddr : bus_awaddr);
                prev_v = bus_arvalid || bus_awvalid;
                if (chk_on && bus_arvalid) chk("bus_araddr", bus_araddr, exp_addr);
                if (chk_on && bus_awvalid) begin
                    chk("bus_awaddr", bus_awaddr, exp_addr);
                    chk("bus_wdata", bus_wdata, exp_wdata);
                    chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
                end
            end else prev_v = 0;
        end
    end

    // Called just after a rising edge; returns just after the edge that ends the response cycle.
    task automatic do_req(input bit lsu, input bit ren, input bit wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input bit scr,
                          output int lat);
        int t0;
        bit got;
        got = 0;
        lat = -1;
        if (lsu) begin
            lsu_avalid = 1; lsu_ren = ren; lsu_wen = wen;
            lsu_addr = addr; lsu_wdata = wdata; lsu_wstrb = strb;
        end else begin
            ifu_avalid = 1; ifu_addr = addr;
        end
        t0 = cyc;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (lsu ? (lsu_rvalid || lsu_wready) : ifu_rvalid) begin
                got = 1;
                lat = cyc - t0;
            end
            @(posedge clk); #1;
            if (scr && k == 0) begin
                if (lsu) begin
                    lsu_addr = ~addr; lsu_wdata = ~wdata; lsu_wstrb = ~strb;
                end else ifu_addr = ~addr;
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no response in 200 cycles required one", lsu ? "lsu" : "ifu");
        end
    endtask

    typedef struct {
        bit          lsu, ren, wen;
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata_cfg;
        int          dly_a, dly_d;
        logic [1:0]  resp;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_lat, exp_ar, exp_aw;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        cfg_a = v.dly_a; cfg_d = v.dly_d; cfg_rdata = v.rdata_cfg; cfg_resp = v.resp;
        exp_addr = v.addr; exp_wdata = v.wdata; exp_wstrb = v.wstrb;
        m_ar_cyc = 0; m_aw_cyc = 0;
        if (v.lsu) lsu_sb.push_back('{v.exp_data, v.exp_err, v.wen});
        else       ifu_sb.push_back('{v.exp_data, v.exp_err, 1'b0});
        @(posedge clk); #1;
        chk_on = 1;
        do_req(v.lsu, v.ren, v.wen, v.addr, v.wdata, v.wstrb, 1'b1, lat);
        ifu_avalid = 0; lsu_avalid = 0; lsu_ren = 0; lsu_wen = 0;
        chk_on = 0;
        chk($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("vec%0d_arvalid_cycles", idx), m_ar_cyc, v.exp_ar);
        chk($sformatf("vec%0d_awvalid_cycles", idx), m_aw_cyc, v.exp_aw);
    endtask

    initial begin
        logic [31:0] exp_g[8];
        vecs[0] = '{0, 0, 0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0413, 0, 0, 2'd0, 32'h0000_0413, 0, 2, 1, 0};
        vecs[1] = '{1, 0, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 3, 0, 2'd0, 32'h0, 0, 5, 0, 4};
        vecs[2] = '{1, 1, 0, 32'h8000_2004, 32'h0, 4'h0, 32'h1122_3344, 1, 2, 2'd2, 32'h3126_3344, 1, 5, 2, 0};
        vecs[3] = '{0, 0, 0, 32'h8000_0004, 32'h0, 4'h0, 32'h0000_0513, 0, 0, 2'd0, 32'h0004_0513, 0, 2, 1, 0};
        vecs[4] = '{1, 1, 1, 32'h8000_3000, 32'h0BAD_F00D, 4'h3, 32'h0, 0, 1, 2'd3, 32'h0, 1, 3, 0, 1};
        vecs[5] = '{0, 0, 0, 32'h8000_0008, 32'h0, 4'h0, 32'hCAFE_0000, 2, 0, 2'd1, 32'hCAF6_0000, 1, 4, 3, 0};
        vecs[6] = '{1, 0, 1, 32'h8000_6000, 32'h1234_5678, 4'hC, 32'h0, 0, 0, 2'd0, 32'h0, 0, 2, 0, 1};

        rst = 1; ifu_avalid = 0; ifu_addr = '0;
        lsu_avalid = 0; lsu_ren = 0; lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arvalid", 32'(bus_arvalid), 0);
        chk("rst_awvalid", 32'(bus_awvalid), 0);
        chk("rst_rsp_valids", 32'({ifu_rvalid, lsu_rvalid, lsu_wready, ifu_err, lsu_err}), 0);
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset while the load waits in the read-data phase: abandoned, no pulse.
        cfg_a = 0; cfg_d = 30; cfg_resp = 0;
        @(posedge clk); #1;
        lsu_avalid = 1; lsu_ren = 1; lsu_wen = 0; lsu_addr = 32'h8000_5000;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("abort_in_read_phase", 32'(s_r_pend), 1);
        rst = 1;
        @(negedge clk);
        chk("abort_rst_cycle_rvalid", 32'(lsu_rvalid), 0);
        @(posedge clk); #1;
        rst = 0; lsu_avalid = 0; lsu_ren = 0;
        @(negedge clk);
        chk("abort_arvalid", 32'(bus_arvalid), 0);
        chk("abort_awvalid", 32'(bus_awvalid), 0);
        chk("abort_rsp_valids", 32'({ifu_rvalid, lsu_rvalid, lsu_wready}), 0);
        run_vec(vecs[0], 10);

        // Both requesters continuously busy: four LSU grants, then fetch is forced.
        cfg_a = 0; cfg_d = 0; cfg_rdata = '0; cfg_resp = 0;
        grant_log.delete();
        @(posedge clk); #1;
        fork
            begin : ifu_proc
                int lat;
                for (int i = 0; i < 2; i++) begin
                    ifu_sb.push_back('{32'h0100_0000 + (i << 18), 1'b0, 1'b0});
                    do_req(0, 0, 0, 32'h8000_0100 + 4 * i, 32'h0, 4'h0, 1'b0, lat);
                end
                ifu_avalid = 0;
            end
            begin : lsu_proc
                int lat;
                for (int i = 0; i < 6; i++) begin
                    lsu_sb.push_back('{32'h4000_0000 + (i << 18), 1'b0, 1'b0});
                    do_req(1, 1, 0, 32'h8000_4000 + 4 * i, 32'h0, 4'h0, 1'b0, lat);
                end
                lsu_avalid = 0; lsu_ren = 0;
            end
        join
        for (int i = 0; i < 4; i++) exp_g[i] = 32'h8000_4000 + 4 * i;
        exp_g[4] = 32'h8000_0100;
        exp_g[5] = 32'h8000_4010;
        exp_g[6] = 32'h8000_4014;
        exp_g[7] = 32'h8000_0104;
        chk("grant_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk($sformatf("grant_order_%0d", i), grant_log[i], exp_g[i]);

        repeat (2) @(posedge clk);
        chk("ifu_sb_leftover", ifu_sb.size(), 0);
        chk("lsu_sb_leftover", lsu_sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
